prco_fetch: RTL and testbench
=============================

# prco_fetch

Instruction fetch stage for the PRCO core, sitting directly upstream of the decoder. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each returned 16-bit instruction to the decoder with a one-cycle `q_ce` pulse. Fetches resume on `i_fetch` (driven by the decoder's `q_fetch` or by downstream completion). Jumps reload the PC through `i_pc_we`, and any read already in flight is flushed.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_en` in 1: stage enable; when low, no new memory request is started.
- `i_fetch` in 1: request for the next instruction; level sampled each edge.
- `i_pc_we` in 1: load PC (jump/branch taken).
- `i_pc_wdata` in 16: new PC value.
- `q_mem_req` out 1: memory read request.
- `q_mem_addr` out 16: word address; stable while `q_mem_req` is high.
- `i_mem_ack` in 1: read data valid this cycle.
- `i_mem_rdata` in 16: read data.
- `q_ce` out 1: one-cycle strobe; `q_instr` is new. Connects to the decoder `i_ce`.
- `q_instr` out 16: last fetched instruction; held until the next `q_ce`.
- `q_pc` out 16: address of `q_instr`.
- `q_busy` out 1: high while a memory read is outstanding (state REQ).

## Operation
- **Registers:**
  - `r_pc` (16): next fetch address.
  - `r_pending` (1): one-deep fetch request latch.
  - `r_flush` (1): discard the in-flight response.
  - State: IDLE or REQ.
- **Reset (async):**
  - state=IDLE; `r_pc`=RESET_PC; `r_pending`=1, so the first fetch is automatic; `r_flush`=0.
  - `q_mem_req`=0, `q_mem_addr`=0, `q_ce`=0, `q_instr`=16'h0000 (NOP), `q_pc`=0, `q_busy`=0.
  - Asserting reset mid-transaction drops `q_mem_req` immediately. A later ack is ignored because state is IDLE.
- **IDLE:**
  - If `i_pc_we`: `r_pc`←`i_pc_wdata`.
  - If `i_en` and (`r_pending` or `i_fetch`):
    - `q_mem_req`←1.
    - `q_mem_addr`←(`i_pc_we` ? `i_pc_wdata` : `r_pc`); a same-cycle jump takes priority.
    - `r_pending`←0; state→REQ.
  - If `i_en`=0: `i_fetch` sets `r_pending`, so the request is not lost.
- **REQ:**
  - Hold `q_mem_req`=1 and `q_mem_addr` until `i_mem_ack`. `i_en` low does not abort a started read.
  - `i_fetch` sets `r_pending`; a single-bit latch, so repeats are merged.
  - `i_pc_we`: `r_pc`←`i_pc_wdata`, `r_flush`←1, `r_pending`←1.
  - **On `i_mem_ack`, not flushed:**
    - `q_instr`←`i_mem_rdata`; `q_pc`←`q_mem_addr`.
    - `r_pc`←`q_mem_addr`+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
    - `q_ce`←1; `q_mem_req`←0; state→IDLE.
  - **On `i_mem_ack`, flushed (`r_flush`, or `i_pc_we` in the same cycle):**
    - Data is discarded; no `q_ce`; `q_instr`/`q_pc` are unchanged.
    - `r_pc` keeps the jump target; `r_flush`←0; `r_pending`←1; state→IDLE.
  - `i_fetch` in the ack cycle sets `r_pending`.
- **Output rules:**
  - `q_ce` is high for exactly one cycle per accepted instruction, then returns to 0.
  - `q_busy` = (state==REQ).
  - `i_mem_rdata` is ignored whenever `i_mem_ack` is low or state is IDLE.

## Timing
- `i_fetch` sampled at edge N (IDLE) → `q_mem_req` high from N.
- Ack at edge N+k (k≥1) → `q_ce` high from N+k for one cycle.
- Zero-wait memory (ack in the first REQ cycle): 2 edges from request to `q_ce`.
- Back-to-back fetch via `r_pending`: one instruction per 2 cycles at zero wait state; the next request issues the edge after `q_ce`.
- A jump in REQ costs the remaining wait plus one new read; it never produces a stale `q_ce`.

## Test plan
- **Boot:** release reset with RESET_PC=16'h0010, `i_en`=1, memory returning 16'h4A05 with zero wait → `q_mem_addr`=16'h0010, `q_ce` pulses once, `q_instr`=16'h4A05, `q_pc`=16'h0010, `r_pc`=16'h0011; no further request until `i_fetch`.
- **Wait states:** ack delayed 3 cycles → `q_mem_req`/`q_mem_addr` are stable for all 3, `q_busy`=1, `q_ce` fires exactly one cycle after ack.
- **Flush:** `i_pc_we`=1 with `i_pc_wdata`=16'h0200 during an outstanding read of 16'h0011, then ack → no `q_ce`; the next request goes to 16'h0200 and its data produces `q_ce` with `q_pc`=16'h0200.
- **Pending merge:** pulse `i_fetch` twice during one REQ → exactly one extra fetch follows; addresses are sequential.
- **Wrap:** PC=16'hFFFF fetched → next `q_mem_addr`=16'h0000.
- **Reset mid-read:** assert `i_reset` while `q_mem_req`=1 → `q_mem_req`, `q_ce` and `q_busy` drop asynchronously; a late ack is ignored; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/prco_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface prco_fetch_if;
    logic        q_mem_req;
    logic [15:0] q_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;

    modport master (
        output q_mem_req,
        output q_mem_addr,
        input  i_mem_ack,
        input  i_mem_rdata
    );

    modport slave (
        input  q_mem_req,
        input  q_mem_addr,
        output i_mem_ack,
        output i_mem_rdata
    );
endinterface

// File: rtl/prco_fetch.sv
// PRCO instruction fetch stage: holds the PC, reads instruction memory over a
// req/ack handshake and hands each instruction to the decoder with a q_ce strobe.
module prco_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_fetch,
    input  logic               i_pc_we,
    input  logic [15:0]        i_pc_wdata,
    prco_fetch_if.master       mem,
    output logic               q_ce,
    output logic [15:0]        q_instr,
    output logic [15:0]        q_pc,
    output logic               q_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic        flush_q, flush_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        ce_q, ce_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;

    logic start_fetch;
    logic flushed_ack;

    assign start_fetch = i_en && (pending_q || i_fetch);
    // A jump landing in the ack cycle must also kill the returning data.
    assign flushed_ack = flush_q || i_pc_we;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            pending_q  <= 1'b1;
            flush_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
            ce_q       <= 1'b0;
            instr_q    <= 16'h0000;
            pc_out_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ce_q       <= ce_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_fetch)   state_d = ST_REQ;
            ST_REQ:  if (mem.i_mem_ack) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d       = pc_q;
        pending_d  = pending_q;
        flush_d    = flush_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ce_d       = 1'b0;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;

        case (state_q)
            ST_IDLE: begin
                if (i_pc_we) pc_d = i_pc_wdata;
                if (start_fetch) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = i_pc_we ? i_pc_wdata : pc_q;
                    pending_d  = 1'b0;
                end else if (i_fetch) begin
                    pending_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (i_fetch) pending_d = 1'b1;
                if (i_pc_we) begin
                    pc_d      = i_pc_wdata;
                    flush_d   = 1'b1;
                    pending_d = 1'b1;
                end
                if (mem.i_mem_ack) begin
                    mem_req_d = 1'b0;
                    if (flushed_ack) begin
                        flush_d   = 1'b0;
                        pending_d = 1'b1;
                    end else begin
                        instr_d  = mem.i_mem_rdata;
                        pc_out_d = mem_addr_q;
                        pc_d     = mem_addr_q + 16'd1;
                        ce_d     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem.q_mem_req  = mem_req_q;
    assign mem.q_mem_addr = mem_addr_q;
    assign q_ce           = ce_q;
    assign q_instr        = instr_q;
    assign q_pc           = pc_out_q;
    assign q_busy         = (state_q == ST_REQ);

endmodule

// File: tb/tb_prco_fetch.sv
// Directed bench for prco_fetch: boot, wait states, flush, pending merge, wrap,
// reset mid-read and fetch requests held while disabled.
module tb_prco_fetch;
    localparam logic [15:0] BOOT_PC = 16'h0010;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic        i_fetch;
    logic        i_pc_we;
    logic [15:0] i_pc_wdata;
    logic        q_ce;
    logic [15:0] q_instr;
    logic [15:0] q_pc;
    logic        q_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    prco_fetch_if mem_if ();

    prco_fetch #(.RESET_PC(BOOT_PC)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_fetch    (i_fetch),
        .i_pc_we    (i_pc_we),
        .i_pc_wdata (i_pc_wdata),
        .mem        (mem_if),
        .q_ce       (q_ce),
        .q_instr    (q_instr),
        .q_pc       (q_pc),
        .q_busy     (q_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic req, input logic [15:0] addr);
        check({tag, "_req"},  16'(mem_if.q_mem_req), 16'(req));
        check({tag, "_busy"}, 16'(q_busy),           16'(req));
        if (req) check({tag, "_addr"}, mem_if.q_mem_addr, addr);
    endtask

    task automatic check_ce(input string tag, input logic ce, input logic [15:0] instr, input logic [15:0] pc);
        check({tag, "_ce"},    16'(q_ce), 16'(ce));
        check({tag, "_instr"}, q_instr,   instr);
        check({tag, "_pc"},    q_pc,      pc);
    endtask

    initial begin
        i_reset            = 1'b1;
        i_en               = 1'b1;
        i_fetch            = 1'b0;
        i_pc_we            = 1'b0;
        i_pc_wdata         = 16'h0000;
        mem_if.i_mem_ack   = 1'b0;
        mem_if.i_mem_rdata = 16'h0000;

        // Reset state
        #2;
        check("rst_req",  16'(mem_if.q_mem_req), 16'h0);
        check("rst_addr", mem_if.q_mem_addr,      16'h0000);
        check_ce("rst", 1'b0, 16'h0000, 16'h0000);
        check("rst_busy", 16'(q_busy), 16'h0);
        #10 i_reset = 1'b0;

        // Boot: automatic first fetch at RESET_PC, zero wait
        tick();
        check_req("boot", 1'b1, 16'h0010);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'h4A05;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("boot", 1'b1, 16'h4A05, 16'h0010);
        check_req("boot_done", 1'b0, 16'h0000);
        tick();
        check("boot_ce_drop", 16'(q_ce), 16'h0);
        tick();
        check_req("boot_quiet", 1'b0, 16'h0000);

        // Wait states: next sequential address, ack after 3 idle cycles
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        check_req("ws_start", 1'b1, 16'h0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_req("ws_hold", 1'b1, 16'h0011);
            check("ws_no_ce", 16'(q_ce), 16'h0);
        end
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'h1234;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("ws", 1'b1, 16'h1234, 16'h0011);
        tick();
        check("ws_ce_drop", 16'(q_ce), 16'h0);

        // Same-cycle jump in IDLE takes priority over the sequential PC
        i_fetch = 1'b1; i_pc_we = 1'b1; i_pc_wdata = 16'h0011;
        tick();
        i_fetch = 1'b0; i_pc_we = 1'b0;
        check_req("jmp_idle", 1'b1, 16'h0011);

        // Flush: jump while the read of 0x0011 is outstanding
        i_pc_we = 1'b1; i_pc_wdata = 16'h0200;
        tick();
        i_pc_we = 1'b0;
        check_req("fl_hold", 1'b1, 16'h0011);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'hDEAD;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("fl_stale", 1'b0, 16'h1234, 16'h0011);
        check("fl_req_drop", 16'(mem_if.q_mem_req), 16'h0);
        tick();
        check_req("fl_refetch", 1'b1, 16'h0200);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'h5555;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("fl_new", 1'b1, 16'h5555, 16'h0200);

        // Pending merge: two i_fetch pulses during one read give one extra fetch
        i_fetch = 1'b1;
        tick();
        check_req("pm_start", 1'b1, 16'h0201);
        tick();
        i_fetch = 1'b0;
        tick();
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'hA001;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("pm_first", 1'b1, 16'hA001, 16'h0201);
        tick();
        check_req("pm_extra", 1'b1, 16'h0202);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'hA002;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("pm_second", 1'b1, 16'hA002, 16'h0202);
        tick();
        check_req("pm_quiet1", 1'b0, 16'h0000);
        tick();
        check_req("pm_quiet2", 1'b0, 16'h0000);

        // Wrap: fetch at 0xFFFF, next address is 0x0000
        i_fetch = 1'b1; i_pc_we = 1'b1; i_pc_wdata = 16'hFFFF;
        tick();
        i_fetch = 1'b0; i_pc_we = 1'b0;
        check_req("wr_top", 1'b1, 16'hFFFF);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'hBEEF;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("wr_top", 1'b1, 16'hBEEF, 16'hFFFF);
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        check_req("wr_zero", 1'b1, 16'h0000);

        // Reset mid-read: outputs drop asynchronously, late ack is ignored
        #2 i_reset = 1'b1;
        #1;
        check("mr_req",  16'(mem_if.q_mem_req), 16'h0);
        check("mr_busy", 16'(q_busy),           16'h0);
        check("mr_ce",   16'(q_ce),             16'h0);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'h9999;
        @(negedge i_clk);
        i_reset = 1'b0;
        tick();
        check_ce("mr_late_ack", 1'b0, 16'h0000, 16'h0000);
        check_req("mr_restart", 1'b1, 16'h0010);
        mem_if.i_mem_rdata = 16'h7777;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("mr_boot", 1'b1, 16'h7777, 16'h0010);

        // Fetch requested while disabled is latched until i_en returns
        i_en = 1'b0; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        check_req("en_off1", 1'b0, 16'h0000);
        tick();
        check_req("en_off2", 1'b0, 16'h0000);
        i_en = 1'b1;
        tick();
        check_req("en_on", 1'b1, 16'h0011);
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 16'h0C0D;
        tick();
        mem_if.i_mem_ack = 1'b0;
        check_ce("en_on", 1'b1, 16'h0C0D, 16'h0011);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
